// File: rtl/xif_coproc_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xif_coproc_responder                                            |
// | Brief    : CORE-V-XIF coprocessor responder for custom-0 instructions.     |
// |            Executes a saturating add (1 cycle) or a radix-2 shift-add      |
// |            32x32 multiply (32 cycles), one instruction in flight.          |
// | Options  : XIF_COPROC_MAC_EN adds a 32-bit accumulator with MAC (010) and  |
// |            ACCCLR (011); undefined, those encodings are rejected.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module xif_coproc_responder #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter logic [6:0]  OPCODE     = 7'h0B
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_rs0_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_COMMIT = 2'd1,
    S_EXEC        = 2'd2,
    S_RESULT      = 2'd3
  } state_t;

  localparam logic [2:0] c_F3_ADDSAT = 3'b000;
  localparam logic [2:0] c_F3_MUL    = 3'b001;
  localparam logic [2:0] c_F3_MAC    = 3'b010;
  localparam logic [2:0] c_F3_ACCCLR = 3'b011;
  localparam logic [5:0] c_MUL_LAST  = 6'd31;

  state_t                r_state;
  logic [X_ID_WIDTH-1:0] r_id;
  logic [4:0]            r_rd;
  logic [2:0]            r_funct3;
  logic [31:0]           r_mcand;        // rs1, shifted left each multiply step
  logic [31:0]           r_mplier;       // rs2, shifted right each multiply step
  logic [31:0]           r_prod;         // running low 32 bits of the product
  logic [5:0]            r_count;
  logic                  r_result_valid;
  logic [31:0]           r_result_data;

  logic [2:0]  w_funct3;
  logic        w_f3_ok;
  logic        w_accept;
  logic        w_take;
  logic        w_issue_commit;
  logic        w_pending_commit;
  logic        w_is_mult;
  logic [32:0] w_sum;
  logic [31:0] w_addsat;
  logic [31:0] w_partial;
  logic [31:0] w_mult_result;
  logic [31:0] w_single_result;
  logic        w_unused;

  assign w_funct3 = issue_instr_i[14:12];

`ifdef XIF_COPROC_MAC_EN
  assign w_f3_ok = (w_funct3[2] == 1'b0);
`else
  assign w_f3_ok = (w_funct3[2:1] == 2'b00);
`endif

  assign w_accept          = (issue_instr_i[6:0] == OPCODE) &&
                             (issue_instr_i[31:25] == 7'd0) && w_f3_ok;
  assign issue_accept_o    = w_accept;
  assign issue_writeback_o = w_accept;

  // Ready is forced low while reset is held even though the state already reads IDLE
  assign issue_ready_o = rst_ni && (r_state == S_IDLE) && (issue_rs_valid_i == 2'b11);

  assign w_take           = issue_valid_i && issue_ready_o && w_accept;
  assign w_issue_commit   = commit_valid_i && (commit_id_i == issue_id_i);
  assign w_pending_commit = commit_valid_i && (commit_id_i == r_id);

  // MUL and MAC share the iterative datapath; ADDSAT and ACCCLR finish in one EXEC cycle
  assign w_is_mult = (r_funct3 == c_F3_MUL) || (r_funct3 == c_F3_MAC);

  assign w_sum     = {1'b0, r_mcand} + {1'b0, r_mplier};
  assign w_addsat  = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
  assign w_partial = r_prod + (r_mplier[0] ? r_mcand : 32'd0);

`ifdef XIF_COPROC_MAC_EN
  logic [31:0] r_acc;
  logic [31:0] w_acc_sum;

  assign w_acc_sum       = r_acc + w_partial;
  assign w_mult_result   = (r_funct3 == c_F3_MAC) ? w_acc_sum : w_partial;
  assign w_single_result = (r_funct3 == c_F3_ACCCLR) ? r_acc : w_addsat;

  // Accumulator only moves in EXEC, so a killed MAC or ACCCLR never touches it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (r_state == S_EXEC) begin
      if ((r_funct3 == c_F3_MAC) && (r_count == c_MUL_LAST)) begin
        r_acc <= w_acc_sum;
      end else if (r_funct3 == c_F3_ACCCLR) begin
        r_acc <= '0;
      end
    end
  end
`else
  assign w_mult_result   = w_partial;
  assign w_single_result = w_addsat;
`endif

  // Register-source fields of the instruction are not needed by this unit
  assign w_unused = ^{issue_instr_i[24:15]};

  // Issue capture, commit tracking, iterative execution and result hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_id           <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_prod         <= '0;
      r_count        <= '0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_id     <= issue_id_i;
            r_rd     <= issue_instr_i[11:7];
            r_funct3 <= w_funct3;
            r_mcand  <= issue_rs0_i;
            r_mplier <= issue_rs1_i;
            r_prod   <= '0;
            r_count  <= '0;
            if (w_issue_commit) begin
              r_state <= commit_kill_i ? S_IDLE : S_EXEC;
            end else begin
              r_state <= S_WAIT_COMMIT;
            end
          end
        end
        S_WAIT_COMMIT: begin
          if (w_pending_commit) begin
            r_state <= commit_kill_i ? S_IDLE : S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mult) begin
            r_prod   <= w_partial;
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_count  <= r_count + 6'd1;
            if (r_count == c_MUL_LAST) begin
              r_count        <= '0;
              r_result_data  <= w_mult_result;
              r_result_valid <= 1'b1;
              r_state        <= S_RESULT;
            end
          end else begin
            r_result_data  <= w_single_result;
            r_result_valid <= 1'b1;
            r_state        <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (result_ready_i) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_valid_o = r_result_valid;
  assign result_we_o    = r_result_valid;
  assign result_data_o  = r_result_data;
  assign result_id_o    = r_id;
  assign result_rd_o    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_xif_coproc_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xif_coproc_responder                                         |
// | Brief    : Self-checking bench for xif_coproc_responder: directed vector   |
// |            table, hand sequences and randomized transactions against a     |
// |            behavioural model. Honours XIF_COPROC_MAC_EN when defined.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_xif_coproc_responder;

  localparam int         IDW = 4;
  localparam logic [6:0] OPC = 7'h0B;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            issue_valid_i = 1'b0;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i = '0;
  logic [IDW-1:0]  issue_id_i = '0;
  logic [31:0]     issue_rs0_i = '0;
  logic [31:0]     issue_rs1_i = '0;
  logic [1:0]      issue_rs_valid_i = 2'b11;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid_i = 1'b0;
  logic [IDW-1:0]  commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            result_valid_o;
  logic            result_ready_i = 1'b0;
  logic [IDW-1:0]  result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  xif_coproc_responder #(.X_ID_WIDTH(IDW), .OPCODE(OPC)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs0_i       (issue_rs0_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_data_o     (result_data_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]    ins;
    logic [IDW-1:0] id;
    logic [31:0]    a;
    logic [31:0]    b;
    int             cdly;     // 0: commit with the issue, k: commit k cycles later
    bit             kill;
    int             rdly;     // cycles result_ready_i is held low
    bit             exp_acc;
    logic [31:0]    exp_data;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, OPC};
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic bit model_accept(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (ins[6:0] != OPC || ins[31:25] != 7'd0) return 1'b0;
`ifdef XIF_COPROC_MAC_EN
    return (f3 <= 3'd3);
`else
    return (f3 <= 3'd1);
`endif
  endfunction

  function automatic int model_latency(input logic [2:0] f3);
    return (f3 == 3'd1 || f3 == 3'd2) ? 33 : 2;
  endfunction

  task automatic model_exec(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            inout logic [31:0] acc, output logic [31:0] res);
    logic [63:0] p;
    longint      s;
    p = {32'd0, a} * {32'd0, b};
    s = longint'({32'd0, a}) + longint'({32'd0, b});
    case (f3)
      3'd0:    res = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
      3'd1:    res = p[31:0];
      3'd2:    begin acc = acc + p[31:0]; res = acc; end
      default: begin res = acc; acc = '0; end
    endcase
  endtask

  // One complete transaction: issue, optional delayed commit, execution, result handshake
  task automatic do_txn(input string tag, input logic [31:0] ins, input logic [IDW-1:0] id,
                        input logic [31:0] a, input logic [31:0] b, input int cdly,
                        input bit kill, input int rdly, input bit exp_acc,
                        input logic [31:0] exp_data);
    int n;
    bit bad;
    issue_valid_i    = 1'b1;
    issue_instr_i    = ins;
    issue_id_i       = id;
    issue_rs0_i      = a;
    issue_rs1_i      = b;
    issue_rs_valid_i = 2'b11;
    if (cdly == 0) begin
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
    end
    #1;
    chk({tag, " ready"}, 32'(issue_ready_o), 32'd1);
    chk({tag, " accept"}, 32'(issue_accept_o), 32'(exp_acc));
    chk({tag, " writeback"}, 32'(issue_writeback_o), 32'(exp_acc));
    step();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    if (!exp_acc || (kill && cdly == 0)) begin
      chk({tag, " stays idle"}, 32'(issue_ready_o), 32'd1);
      chk({tag, " no result"}, 32'(result_valid_o), 32'd0);
      return;
    end
    if (cdly > 0) begin
      bad = 1'b0;
      for (int i = 1; i < cdly; i++) begin
        if (issue_ready_o !== 1'b0 || result_valid_o !== 1'b0) bad = 1'b1;
        step();
      end
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      #1;
      if (issue_ready_o !== 1'b0) bad = 1'b1;
      step();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      chk({tag, " busy before commit"}, 32'(bad), 32'd0);
      if (kill) begin
        chk({tag, " kill ready"}, 32'(issue_ready_o), 32'd1);
        chk({tag, " kill no result"}, 32'(result_valid_o), 32'd0);
        return;
      end
    end
    n   = 0;
    bad = 1'b0;
    while (result_valid_o !== 1'b1 && n < 40) begin
      if (issue_ready_o !== 1'b0) bad = 1'b1;
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n + 1), 32'(model_latency(ins[14:12])));
    chk({tag, " ready low in exec"}, 32'(bad), 32'd0);
    chk({tag, " data"}, result_data_o, exp_data);
    chk({tag, " id"}, 32'(result_id_o), 32'(id));
    chk({tag, " rd"}, 32'(result_rd_o), 32'(ins[11:7]));
    chk({tag, " we"}, 32'(result_we_o), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      step();
      if (result_valid_o !== 1'b1 || result_data_o !== exp_data ||
          result_id_o !== id || issue_ready_o !== 1'b0) bad = 1'b1;
    end
    chk({tag, " hold under backpressure"}, 32'(bad), 32'd0);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    chk({tag, " valid drops"}, 32'(result_valid_o), 32'd0);
    chk({tag, " idle after result"}, 32'(issue_ready_o), 32'd1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ins, a, b, ed;
    int          r, cdly, rdly;
    bit          kill, eacc;

    // Directed vectors: {ins, id, a, b, cdly, kill, rdly, exp_acc, exp_data}
    vecs.push_back('{mk(7'd0, 3'd0, 5'd5),  4'd3,  32'hFFFF_FFF0, 32'h20,        0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{mk(7'd0, 3'd0, 5'd1),  4'd1,  32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0, 1, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{mk(7'd0, 3'd0, 5'd31), 4'd15, 32'd1,         32'd2,         2, 1'b0, 0, 1'b1, 32'd3});
    vecs.push_back('{mk(7'd0, 3'd1, 5'd10), 4'd4,  32'd7,         32'd6,         4, 1'b0, 0, 1'b1, 32'd42});
    vecs.push_back('{mk(7'd0, 3'd1, 5'd7),  4'd6,  32'h1_0000,    32'h1_0000,    0, 1'b0, 5, 1'b1, 32'd0});
    vecs.push_back('{mk(7'd0, 3'd1, 5'd8),  4'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 0, 1'b1, 32'd1});
    vecs.push_back('{mk(7'd0, 3'd1, 5'd9),  4'd9,  32'h1234_5678, 32'h10,        0, 1'b0, 0, 1'b1, 32'h2345_6780});
    vecs.push_back('{mk(7'd0, 3'd5, 5'd2),  4'd2,  32'd1,         32'd1,         0, 1'b0, 0, 1'b0, 32'd0});
    vecs.push_back('{mk(7'd1, 3'd0, 5'd2),  4'd2,  32'd1,         32'd1,         0, 1'b0, 0, 1'b0, 32'd0});
    vecs.push_back('{mk(7'd0, 3'd6, 5'd2),  4'd2,  32'd1,         32'd1,         0, 1'b0, 0, 1'b0, 32'd0});
    vecs.push_back('{{25'd0, 7'h33},        4'd5,  32'd1,         32'd1,         0, 1'b0, 0, 1'b0, 32'd0});
    vecs.push_back('{mk(7'd0, 3'd0, 5'd4),  4'd8,  32'd5,         32'd5,         0, 1'b1, 0, 1'b1, 32'd0});

    // Reset state
    #1;
    chk("reset ready", 32'(issue_ready_o), 32'd0);
    chk("reset valid", 32'(result_valid_o), 32'd0);
    chk("reset data", result_data_o, 32'd0);
    chk("reset id", 32'(result_id_o), 32'd0);
    chk("reset rd", 32'(result_rd_o), 32'd0);
    chk("reset we", 32'(result_we_o), 32'd0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    issue_rs_valid_i = 2'b01;
    #1;
    chk("ready needs both operands", 32'(issue_ready_o), 32'd0);
    issue_rs_valid_i = 2'b11;
    #1;
    chk("ready idle", 32'(issue_ready_o), 32'd1);
    step();

    foreach (vecs[i]) begin
      do_txn($sformatf("vec%0d", i), vecs[i].ins, vecs[i].id, vecs[i].a, vecs[i].b,
             vecs[i].cdly, vecs[i].kill, vecs[i].rdly, vecs[i].exp_acc, vecs[i].exp_data);
    end

    // Non-matching commit is ignored, then a matching kill drops the instruction
    issue_valid_i = 1'b1;
    issue_instr_i = mk(7'd0, 3'd0, 5'd3);
    issue_id_i    = 4'd2;
    issue_rs0_i   = 32'd10;
    issue_rs1_i   = 32'd20;
    #1;
    chk("kill seq accept", 32'(issue_accept_o), 32'd1);
    step();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd1;
    commit_kill_i  = 1'b0;
    step();
    commit_valid_i = 1'b0;
    step();
    step();
    chk("mismatch commit ignored valid", 32'(result_valid_o), 32'd0);
    chk("mismatch commit still busy", 32'(issue_ready_o), 32'd0);
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd2;
    commit_kill_i  = 1'b1;
    step();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    chk("kill ready next cycle", 32'(issue_ready_o), 32'd1);
    step();
    step();
    chk("kill no result", 32'(result_valid_o), 32'd0);

    // Reset during the 10th EXEC cycle of a multiply
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk(7'd0, 3'd1, 5'd12);
    issue_id_i     = 4'd11;
    issue_rs0_i    = 32'd7;
    issue_rs1_i    = 32'd6;
    commit_valid_i = 1'b1;
    commit_id_i    = 4'd11;
    step();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    repeat (9) step();
    rst_ni = 1'b0;
    #1;
    chk("midreset ready", 32'(issue_ready_o), 32'd0);
    chk("midreset valid", 32'(result_valid_o), 32'd0);
    chk("midreset data", result_data_o, 32'd0);
    chk("midreset id", 32'(result_id_o), 32'd0);
    chk("midreset rd", 32'(result_rd_o), 32'd0);
    chk("midreset we", 32'(result_we_o), 32'd0);
    step();
    rst_ni = 1'b1;
    model_acc = '0;
    step();
    chk("after reset idle", 32'(issue_ready_o), 32'd1);
    repeat (25) step();
    chk("interrupted mul emits nothing", 32'(result_valid_o), 32'd0);
    do_txn("post-reset addsat", mk(7'd0, 3'd0, 5'd6), 4'd1, 32'd1, 32'd2, 0, 1'b0, 0, 1'b1, 32'd3);

`ifdef XIF_COPROC_MAC_EN
    do_txn("mac 3x4", mk(7'd0, 3'd2, 5'd1), 4'd1, 32'd3, 32'd4, 0, 1'b0, 0, 1'b1, 32'd12);
    do_txn("mac 5x5", mk(7'd0, 3'd2, 5'd2), 4'd2, 32'd5, 32'd5, 1, 1'b0, 1, 1'b1, 32'd37);
    do_txn("killed mac", mk(7'd0, 3'd2, 5'd3), 4'd3, 32'd9, 32'd9, 2, 1'b1, 0, 1'b1, 32'd0);
    do_txn("killed accclr", mk(7'd0, 3'd3, 5'd3), 4'd3, 32'd0, 32'd0, 0, 1'b1, 0, 1'b1, 32'd0);
    do_txn("accclr", mk(7'd0, 3'd3, 5'd4), 4'd4, 32'd0, 32'd0, 0, 1'b0, 0, 1'b1, 32'd37);
    do_txn("mac 1x1", mk(7'd0, 3'd2, 5'd5), 4'd5, 32'd1, 32'd1, 0, 1'b0, 0, 1'b1, 32'd1);
    model_acc = 32'd1;
`endif

    // Randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 3));
      if (r == 0) f3 = 3'($urandom_range(4, 7));
      f7 = (r == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      cdly = $urandom_range(0, 3);
      kill = ($urandom_range(0, 6) == 0);
      rdly = $urandom_range(0, 2);
      ins  = mk(f7, f3, 5'($urandom_range(0, 31)));
      eacc = model_accept(ins);
      ed   = '0;
      if (eacc && !kill) model_exec(f3, a, b, model_acc, ed);
      do_txn($sformatf("rnd%0d", t), ins, 4'($urandom_range(0, 15)), a, b,
             cdly, kill, rdly, eacc, ed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
